// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID register, single-outstanding req/gnt/rvalid instruction fetch.
// Optional build macro FETCH_PERF_CNT_EN adds delivered/discarded response counters.
//  state | meaning
//  IDLE  | no request outstanding
//  REQ   | request on the bus, waiting for gnt
//  WAIT  | request granted, waiting for rvalid
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        pc_src_e_i,
    input  logic [31:0] pc_target_e_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc_plus4_d_o,
    output logic        valid_d_o,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_kill_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        stale_q, stale_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
    logic        valid_d_q, valid_d_d;

    logic rsp_wait;
    logic deliver;
    logic buf_fill;
    logic buf_avail;
    logic launch;
    logic start;

    assign rsp_wait  = (state_q == ST_WAIT) && imem_rvalid_i;
    assign deliver   = rsp_wait && !stale_q && !pc_src_e_i;
    assign buf_fill  = deliver && stall_d_i && !flush_d_i;
    assign buf_avail = buf_valid_q && !pc_src_e_i;
    // A response being parked this cycle counts as a full buffer, so no launch can overflow it.
    assign launch    = !stall_f_i && !pc_src_e_i && !buf_valid_q && !buf_fill;
    assign start     = launch && ((state_q == ST_IDLE) || rsp_wait);

    always_comb begin
        state_d    = state_q;
        pc_f_d     = pc_f_q;
        req_addr_d = req_addr_q;
        stale_d    = stale_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_REQ;
            ST_REQ:  if (imem_gnt_i) state_d = ST_WAIT;
            ST_WAIT: if (imem_rvalid_i) state_d = launch ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            req_addr_d = pc_f_q;
            pc_f_d     = pc_f_q + 32'd4;
            stale_d    = 1'b0;
        end
        // An in-flight request keeps its old address; its response is marked stale instead.
        if (pc_src_e_i) begin
            pc_f_d = pc_target_e_i & ~32'd3;
            if (state_q != ST_IDLE) stale_d = 1'b1;
        end
    end

    always_comb begin
        instr_d_d    = instr_d_q;
        pc_d_d       = pc_d_q;
        pc_plus4_d_d = pc_plus4_d_q;
        valid_d_d    = valid_d_q;
        buf_valid_d  = buf_valid_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        if (flush_d_i) begin
            instr_d_d = NOP_INSTR;
            valid_d_d = 1'b0;
        end else if (stall_d_i) begin
            if (deliver) begin
                buf_valid_d = 1'b1;
                buf_instr_d = imem_rdata_i;
                buf_pc_d    = req_addr_q;
            end
        end else if (buf_avail) begin
            instr_d_d    = buf_instr_q;
            pc_d_d       = buf_pc_q;
            pc_plus4_d_d = buf_pc_q + 32'd4;
            valid_d_d    = 1'b1;
            buf_valid_d  = 1'b0;
        end else if (deliver) begin
            instr_d_d    = imem_rdata_i;
            pc_d_d       = req_addr_q;
            pc_plus4_d_d = req_addr_q + 32'd4;
            valid_d_d    = 1'b1;
        end else begin
            instr_d_d = NOP_INSTR;
            valid_d_d = 1'b0;
        end
        if (pc_src_e_i) buf_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            pc_f_q       <= RESET_PC;
            req_addr_q   <= RESET_PC;
            stale_q      <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_instr_q  <= NOP_INSTR;
            buf_pc_q     <= 32'd0;
            instr_d_q    <= NOP_INSTR;
            pc_d_q       <= 32'd0;
            pc_plus4_d_q <= 32'd0;
            valid_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            req_addr_q   <= req_addr_d;
            stale_q      <= stale_d;
            buf_valid_q  <= buf_valid_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_d_q    <= valid_d_d;
        end
    end

    assign imem_req_o   = (state_q == ST_REQ);
    assign imem_addr_o  = req_addr_q;
    assign instr_d_o    = instr_d_q;
    assign pc_d_o       = pc_d_q;
    assign pc_plus4_d_o = pc_plus4_d_q;
    assign valid_d_o    = valid_d_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_kill_q;
    logic        id_load;
    logic        discard;

    assign id_load = !flush_d_i && !stall_d_i && (buf_avail || deliver);
    assign discard = rsp_wait && (stale_q || pc_src_e_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_fetch_q <= 32'd0;
            perf_kill_q  <= 32'd0;
        end else begin
            if (id_load) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (discard) perf_kill_q  <= perf_kill_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_kill_o  = perf_kill_q;
`else
    assign perf_fetch_o = 32'd0;
    assign perf_kill_o  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: reactive imem model plus scoreboard of instructions expected in IF/ID.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        stall_f_i, stall_d_i, flush_d_i, pc_src_e_i;
    logic [31:0] pc_target_e_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_d_o, pc_d_o, pc_plus4_d_o;
    logic        valid_d_o;
    logic [31:0] perf_fetch_o, perf_kill_o;

    always #5 clk_i = ~clk_i;

    fetch_stage dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .stall_f_i     (stall_f_i),
        .stall_d_i     (stall_d_i),
        .flush_d_i     (flush_d_i),
        .pc_src_e_i    (pc_src_e_i),
        .pc_target_e_i (pc_target_e_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_d_o     (instr_d_o),
        .pc_d_o        (pc_d_o),
        .pc_plus4_d_o  (pc_plus4_d_o),
        .valid_d_o     (valid_d_o),
        .perf_fetch_o  (perf_fetch_o),
        .perf_kill_o   (perf_kill_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[19:0], 12'h093};
    endfunction

    // imem model: grant after gnt_delay waiting cycles, respond the cycle after grant
    bit          mem_en = 1'b1;
    bit          mem_pend = 1'b0;
    logic [31:0] mem_pend_addr;
    logic [31:0] held_addr;
    int          gnt_delay = 0;
    int          gnt_cnt = 0;
    int          kill_next = 0;
    int          n_kill = 0;
    int          n_deliv = 0;
    bit          force_en = 1'b0;
    logic [31:0] force_data = 32'd0;

    initial forever begin
        logic [31:0] rd;
        @(negedge clk_i);
        if (mem_en) begin
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            if (mem_pend) begin
                chk("one_outstanding", 32'(imem_req_o), 32'd0);
                rd = force_en ? force_data : instr_of(mem_pend_addr);
                force_en = 1'b0;
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = rd;
                mem_pend = 1'b0;
                if (kill_next > 0) begin
                    kill_next--;
                    n_kill++;
                end else begin
                    sb_q.push_back('{pc: mem_pend_addr, instr: rd});
                end
            end else if (imem_req_o) begin
                if (gnt_cnt == 0) held_addr = imem_addr_o;
                else chk("req_addr_stable", imem_addr_o, held_addr);
                if (gnt_cnt >= gnt_delay) begin
                    imem_gnt_i    = 1'b1;
                    mem_pend      = 1'b1;
                    mem_pend_addr = imem_addr_o;
                    gnt_cnt       = 0;
                end else begin
                    gnt_cnt++;
                end
            end
        end else begin
            mem_pend = 1'b0;
            gnt_cnt  = 0;
        end
    end

    // IF/ID monitor: every unheld edge that leaves valid_d=1 is a fresh delivery
    int cyc = 0;
    int last_deliv = -1;
    bit gap_chk = 1'b0;

    initial forever begin
        bit   held;
        exp_t e;
        @(posedge clk_i);
        held = stall_d_i || flush_d_i || !rst_n_i;
        cyc++;
        #1;
        if (!held && valid_d_o) begin
            n_deliv++;
            if (gap_chk && last_deliv >= 0) chk("deliver_gap", 32'(cyc - last_deliv), 32'd2);
            last_deliv = cyc;
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("pc_d", pc_d_o, e.pc);
                chk("instr_d", instr_d_o, e.instr);
                chk("pc_plus4_d", pc_plus4_d_o, e.pc + 32'd4);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rst_n_i = 1'b0;
        stall_f_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0;
        pc_src_e_i = 1'b0; pc_target_e_i = 32'd0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
        tick(3);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_instr", instr_d_o, NOP);
        chk("rst_pc", pc_d_o, 32'd0);
        chk("rst_pc4", pc_plus4_d_o, 32'd0);
        chk("rst_valid", 32'(valid_d_o), 32'd0);
        chk("rst_perf_fetch", perf_fetch_o, 32'd0);
        chk("rst_perf_kill", perf_kill_o, 32'd0);

        // streaming with zero-wait memory
        rst_n_i = 1'b1;
        gap_chk = 1'b1;
        tick(7);
        stall_f_i = 1'b1;
        tick(6);
        gap_chk = 1'b0;
        chk("s1_deliveries", 32'(n_deliv), 32'd4);
        chk("s1_drained", 32'(sb_q.size()), 32'd0);

        // grant withheld for three cycles
        gnt_delay = 3;
        stall_f_i = 1'b0;
        tick(1);
        stall_f_i = 1'b1;
        tick(1);
        chk("s2_req_held_a", 32'(imem_req_o), 32'd1);
        chk("s2_addr_a", imem_addr_o, 32'h10);
        tick(1);
        chk("s2_req_held_b", 32'(imem_req_o), 32'd1);
        chk("s2_addr_b", imem_addr_o, 32'h10);
        tick(5);
        gnt_delay = 0;
        chk("s2_drained", 32'(sb_q.size()), 32'd0);

        // decode stall across the response
        force_data = 32'h0050_0093;
        force_en   = 1'b1;
        stall_f_i  = 1'b0;
        tick(1);
        stall_d_i = 1'b1;
        tick(2);
        chk("s3_no_req_a", 32'(imem_req_o), 32'd0);
        chk("s3_hold_valid", 32'(valid_d_o), 32'd0);
        chk("s3_hold_instr", instr_d_o, NOP);
        chk("s3_hold_pc", pc_d_o, 32'h10);
        tick(1);
        chk("s3_no_req_b", 32'(imem_req_o), 32'd0);
        tick(1);
        chk("s3_no_req_c", 32'(imem_req_o), 32'd0);
        stall_d_i = 1'b0;
        stall_f_i = 1'b1;
        tick(1);
        chk("s3_release_instr", instr_d_o, 32'h0050_0093);
        chk("s3_release_valid", 32'(valid_d_o), 32'd1);
        tick(4);
        chk("s3_drained", 32'(sb_q.size()), 32'd0);

        // redirect while waiting for the response
        kill_next = 1;
        stall_f_i = 1'b0;
        tick(2);
        pc_src_e_i = 1'b1;
        pc_target_e_i = 32'h0000_0103;
        tick(1);
        pc_src_e_i = 1'b0;
        chk("s4_kill_valid", 32'(valid_d_o), 32'd0);
        chk("s4_kill_count", 32'(n_kill), 32'd1);
        tick(1);
        chk("s4_redirect_req", 32'(imem_req_o), 32'd1);
        chk("s4_redirect_addr", imem_addr_o, 32'h100);
        stall_f_i = 1'b1;
        tick(4);
        pc_src_e_i = 1'b1;
        pc_target_e_i = 32'hFFFF_FFFE;
        tick(1);
        pc_src_e_i = 1'b0;
        stall_f_i  = 1'b0;
        tick(1);
        chk("s4_wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        stall_f_i = 1'b1;
        tick(5);
        chk("s4_drained", 32'(sb_q.size()), 32'd0);

        // flush and stall in the same cycle
        stall_f_i = 1'b0;
        tick(1);
        stall_f_i = 1'b1;
        tick(2);
        stall_d_i = 1'b1;
        tick(1);
        chk("s5_held_valid", 32'(valid_d_o), 32'd1);
        flush_d_i = 1'b1;
        tick(1);
        chk("s5_flush_instr", instr_d_o, NOP);
        chk("s5_flush_valid", 32'(valid_d_o), 32'd0);
        flush_d_i = 1'b0;
        stall_d_i = 1'b0;
        tick(3);
        chk("s5_drained", 32'(sb_q.size()), 32'd0);

        // reset while waiting for the response, then a stray rvalid
        stall_f_i = 1'b0;
        tick(1);
        stall_f_i = 1'b1;
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        mem_en  = 1'b0;
        n_deliv = 0;
        n_kill  = 0;
        tick(1);
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        chk("s6_rst_req", 32'(imem_req_o), 32'd0);
        chk("s6_rst_addr", imem_addr_o, 32'd0);
        chk("s6_rst_instr", instr_d_o, NOP);
        chk("s6_rst_valid", 32'(valid_d_o), 32'd0);
        tick(1);
        rst_n_i = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        tick(1);
        imem_rvalid_i = 1'b0;
        chk("s6_stray_valid", 32'(valid_d_o), 32'd0);
        chk("s6_stray_instr", instr_d_o, NOP);
        chk("s6_stray_pc", pc_d_o, 32'd0);
        chk("s6_stray_req", 32'(imem_req_o), 32'd0);
        mem_en = 1'b1;
        stall_f_i = 1'b0;
        tick(1);
        chk("s6_first_req", 32'(imem_req_o), 32'd1);
        chk("s6_first_addr", imem_addr_o, 32'd0);
        stall_f_i = 1'b1;
        tick(5);
        chk("s6_deliveries", 32'(n_deliv), 32'd1);
        chk("s6_drained", 32'(sb_q.size()), 32'd0);

`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_o, 32'(n_deliv));
        chk("perf_kill", perf_kill_o, 32'(n_kill));
`else
        chk("perf_fetch_tied", perf_fetch_o, 32'd0);
        chk("perf_kill_tied", perf_kill_o, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got %0d compared expected completion", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
